priv_trap_sequencer: RTL
========================

# priv_trap_sequencer

Sequencing controller for trap entry and trap return in the privilege block. It accepts trap requests from the interrupt/exception handler and `mret`/`sret` from the pipeline, and waits for the pipeline to drain. It then grants a one-cycle CSR commit window and drives the redirect PC into fetch with a hold-until-accepted handshake. It replaces the purely combinational PC-insert path so that CSR injection and PC redirection are ordered and observable.

## Interface
Parameters:
- `DRAIN_TIMEOUT`, 64: max cycles spent in DRAIN before forcing progress; must be ≥2.
- `TRAP_CNT_W`, 16: width of `trap_count`.

Ports:
- `CLK` in 1: single clock; all state updates on rising edge.
- `RST` in 1: synchronous, active-high reset.
- `intr` in 1: trap request (interrupt or exception) from the int/ex handler, level.
- `intr_to_s` in 1: trap targets S-mode; sampled with `intr`.
- `mret`, `sret` in 1: return request from the pipeline, level.
- `pipe_clear` in 1: pipeline holds no in-flight hazards.
- `ex_mem_stall` in 1: EX/MEM stage stalled.
- `curr_mtvec`, `curr_stvec` in 32: trap vector CSRs; [1:0] mode (0 direct, 1 vectored), [31:2] base.
- `curr_mepc`, `curr_sepc` in 32: return addresses.
- `next_mcause`, `next_scause` in 32: bit 31 interrupt flag, [30:0] cause code.
- `pc_accept` in 1: fetch has taken `priv_pc`.
- `insert_pc` out 1: redirect request to fetch.
- `priv_pc` out 32: redirect target.
- `csr_commit` out 1: one-cycle strobe; the int/ex handler applies its `inject_*` writes only in this cycle.
- `trap_busy` out 1: sequence in progress; fetch must stall.
- `drain_timeout` out 1: sticky; set when a drain expired.
- `trap_count` out `TRAP_CNT_W`: traps completed, wraps modulo 2^`TRAP_CNT_W`.

## Operation
- States are IDLE, DRAIN, COMMIT and REDIRECT. A 2-bit `kind` register holds TRAP_M, TRAP_S, RET_M or RET_S.
- **IDLE**
  - Priority is `intr` > `mret` > `sret`.
  - On any request, latch `kind`, latch the cause (`next_scause` if `intr_to_s`, else `next_mcause`), clear the drain counter and go to DRAIN.
- **DRAIN**
  - Counter increments each cycle.
  - Go to COMMIT when `pipe_clear && !ex_mem_stall`.
  - Also go to COMMIT when the counter equals `DRAIN_TIMEOUT-1`, and set `drain_timeout`.
  - If `intr` rises while `kind` is RET_*, overwrite `kind` and the cause with the trap. The counter is not restarted.
- **COMMIT**
  - `csr_commit`=1 for exactly one cycle.
  - Compute the target into the `priv_pc` register:
    - TRAP_M uses `curr_mtvec`; TRAP_S uses `curr_stvec`.
    - Target = {tvec[31:2],2'b00}.
    - If tvec mode==1 and cause[31]==1, add cause[30:0]<<2, truncated to 32 bits.
    - Mode values 2 and 3 are treated as direct.
    - RET_M uses {`curr_mepc`[31:2],2'b00}; RET_S uses {`curr_sepc`[31:2],2'b00}.
  - Go to REDIRECT.
- **REDIRECT**
  - `insert_pc`=1 and `priv_pc` is held stable until `pc_accept`.
  - On `pc_accept`, go to IDLE. If `kind` is TRAP_*, increment `trap_count`.
  - New requests are ignored here and re-sampled in IDLE.
- `trap_busy` = (state != IDLE).
- Reset values:
  - State IDLE.
  - Outputs `insert_pc`, `csr_commit`, `trap_busy` and `drain_timeout` are 0.
  - `priv_pc`=0 and `trap_count`=0.
  - `kind`, the cause register and the drain counter are 0.
- `RST` asserted in any state returns to IDLE the next edge. It drops `insert_pc` and does not pulse `csr_commit`.

## Timing
- All outputs are registered or decoded from the registered state; there is no combinational input-to-output path.
- Minimum latency, with request at cycle 0 and `pipe_clear`=1:
  - Cycle 1: DRAIN.
  - Cycle 2: COMMIT, `csr_commit`=1.
  - Cycle 3: REDIRECT, `insert_pc`=1.
  - Cycle 4: IDLE, if `pc_accept` arrived in cycle 3.
- DRAIN always lasts at least 1 cycle and at most `DRAIN_TIMEOUT` cycles.
- CSR inputs are sampled only in COMMIT. Values seen in IDLE or DRAIN do not affect `priv_pc`.
- `pc_accept` outside REDIRECT is ignored.
- If `pc_accept` and a new request arrive in the same cycle, the new request is taken one cycle later from IDLE.

## Test plan
- **Direct M trap:** `intr`=1, `intr_to_s`=0, `next_mcause`=0x0000_0002, `curr_mtvec`=0x8000_0101, `pipe_clear`=1, `pc_accept`=1 in the first REDIRECT cycle. Expect `csr_commit` in cycle 2, `insert_pc` with `priv_pc`=0x8000_0100 in cycle 3, IDLE in cycle 4, `trap_count`=1.
- **Vectored S interrupt:** `intr_to_s`=1, `next_scause`=0x8000_0005, `curr_stvec`=0x0000_2001. Expect `priv_pc`=0x0000_2014.
- **mret drain:** `mret`=1, `curr_mepc`=0x0000_4006, `pipe_clear` low for 5 cycles. Expect DRAIN for 6 cycles, then `priv_pc`=0x0000_4004; `trap_count` unchanged.
- **Timeout:** `DRAIN_TIMEOUT`=8, `pipe_clear`=0 forever. Expect COMMIT on the 9th cycle after the request, `drain_timeout`=1 and staying 1 through later traps until `RST`.
- **Preemption and priority:**
  - `sret` enters DRAIN, then `intr` rises. Expect a trap target, `trap_count`+1.
  - `intr` and `mret` in the same IDLE cycle: trap wins.
- **Handshake and reset:**
  - Withhold `pc_accept` for 10 cycles. Expect `insert_pc` and `priv_pc` stable throughout.
  - Assert `RST` in the 4th held cycle. Expect all outputs 0 next cycle and no `trap_count` increment.

Source files
------------

// File: rtl/priv_trap_sequencer.sv
// Orders trap entry / trap return: drain the pipeline, grant a one-cycle CSR commit window,
// then hold the redirect PC toward fetch until it is accepted. Min latency request->insert_pc is 3 cycles.
module priv_trap_sequencer #(
   parameter int DRAIN_TIMEOUT = 64,
   parameter int TRAP_CNT_W    = 16
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  intr,
   input  logic                  intr_to_s,
   input  logic                  mret,
   input  logic                  sret,
   input  logic                  pipe_clear,
   input  logic                  ex_mem_stall,
   input  logic [31:0]           curr_mtvec,
   input  logic [31:0]           curr_stvec,
   input  logic [31:0]           curr_mepc,
   input  logic [31:0]           curr_sepc,
   input  logic [31:0]           next_mcause,
   input  logic [31:0]           next_scause,
   input  logic                  pc_accept,
   output logic                  insert_pc,
   output logic [31:0]           priv_pc,
   output logic                  csr_commit,
   output logic                  trap_busy,
   output logic                  drain_timeout,
   output logic [TRAP_CNT_W-1:0] trap_count
);

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_DRAIN    = 2'd1;
   localparam logic [1:0] S_COMMIT   = 2'd2;
   localparam logic [1:0] S_REDIRECT = 2'd3;

   // kind[1] set means a return; traps are the low two encodings
   localparam logic [1:0] K_TRAP_M = 2'd0;
   localparam logic [1:0] K_TRAP_S = 2'd1;
   localparam logic [1:0] K_RET_M  = 2'd2;
   localparam logic [1:0] K_RET_S  = 2'd3;

   localparam int              CNT_W    = $clog2(DRAIN_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_TIMEOUT - 1);

   logic [1:0]       state;
   logic [1:0]       kind;
   logic [31:0]      cause;
   logic [CNT_W-1:0] drain_cnt;

   logic [31:0] tvec;
   logic [31:0] vec_off;
   logic [31:0] trap_pc;
   logic [31:0] target_pc;
   logic [1:0]  trap_kind;
   logic [31:0] trap_cause;

   assign trap_kind  = intr_to_s ? K_TRAP_S : K_TRAP_M;
   assign trap_cause = intr_to_s ? next_scause : next_mcause;

   always_comb begin
      tvec      = (kind == K_TRAP_S) ? curr_stvec : curr_mtvec;
      vec_off   = {1'b0, cause[30:0]} << 2;
      trap_pc   = tvec & 32'hFFFF_FFFC;
      if (tvec[1:0] == 2'b01 && cause[31])
         trap_pc = trap_pc + vec_off;
      case (kind)
         K_RET_M: target_pc = curr_mepc & 32'hFFFF_FFFC;
         K_RET_S: target_pc = curr_sepc & 32'hFFFF_FFFC;
         default: target_pc = trap_pc;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state         <= S_IDLE;
         kind          <= K_TRAP_M;
         cause         <= '0;
         drain_cnt     <= '0;
         priv_pc       <= '0;
         drain_timeout <= 1'b0;
         trap_count    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (intr || mret || sret) begin
                  kind      <= intr ? trap_kind : (mret ? K_RET_M : K_RET_S);
                  cause     <= trap_cause;
                  drain_cnt <= '0;
                  state     <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               drain_cnt <= drain_cnt + 1'b1;
               // A trap arriving during a return drain takes over; the drain budget keeps running
               if (intr && kind[1]) begin
                  kind  <= trap_kind;
                  cause <= trap_cause;
               end
               if (pipe_clear && !ex_mem_stall) begin
                  state <= S_COMMIT;
               end else if (drain_cnt == CNT_LAST) begin
                  state         <= S_COMMIT;
                  drain_timeout <= 1'b1;
               end
            end
            S_COMMIT: begin
               priv_pc <= target_pc;
               state   <= S_REDIRECT;
            end
            default: begin
               if (pc_accept) begin
                  state <= S_IDLE;
                  if (!kind[1])
                     trap_count <= trap_count + 1'b1;
               end
            end
         endcase
      end
   end

   assign insert_pc  = (state == S_REDIRECT);
   assign csr_commit = (state == S_COMMIT);
   assign trap_busy  = (state != S_IDLE);

endmodule
